// File: rtl/rx_tx.sv
// Full-duplex UART transceiver: 8 data bits LSB first, even parity, one stop bit.
// RX and TX run independently from the same bit-period divider constant.
module rx_tx #(
  parameter int unsigned CLK_HZ = 25_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       tx,
  output logic       txrdy
);

  localparam int unsigned Div  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(Div + 1);
  localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic {TxIdle, TxBusy} tx_state_e;

  rx_state_e       rx_state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_par_q;
  logic            rx_vld_q;
  logic [7:0]      rx_data_q;

  tx_state_e       tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_left_q;
  logic [9:0]      tx_shift_q;
  logic            tx_q;
  logic            txrdy_q;

  // Receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_vld_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_vld_q  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxParity;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxParity: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q <= '0;
            if (rx_sync_q && (rx_par_q == ^rx_shift_q)) begin
              rx_data_q <= rx_shift_q;
              rx_vld_q  <= 1'b1;
            end
            // Back to idle mid-stop so the next start edge is not missed.
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Transmitter: start bit goes out on the accepting edge; stop, parity, data queued in a shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
      txrdy_q    <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_vld) begin
            tx_shift_q <= {1'b1, ^tx_data, tx_data};
            tx_q       <= 1'b0;
            txrdy_q    <= 1'b0;
            tx_cnt_q   <= '0;
            tx_left_q  <= 4'd10;
            tx_state_q <= TxBusy;
          end
        end
        TxBusy: begin
          if (tx_cnt_q == DivLast) begin
            tx_cnt_q <= '0;
            if (tx_left_q == 4'd0) begin
              tx_q       <= 1'b1;
              txrdy_q    <= 1'b1;
              tx_state_q <= TxIdle;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[9:1]};
              tx_left_q  <= tx_left_q - 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign rx_vld  = rx_vld_q;
  assign rx_data = rx_data_q;
  assign tx      = tx_q;
  assign txrdy   = txrdy_q;

endmodule

// File: tb/tb_rx_tx.sv
// Bench for rx_tx: directed frames plus randomized full-duplex traffic, checked every
// cycle against a frame-level model (TX bit timeline, RX expected-byte scoreboard).
module tb_rx_tx;

  localparam int DIV = 16;
  localparam int RX_LAT = 3 + DIV / 2 + 10 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       tx;
  logic       txrdy;

  rx_tx #(
    .CLK_HZ(25_000_000),
    .BAUD  (1_562_500)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .tx_vld (tx_vld),
    .tx_data(tx_data),
    .rx_vld (rx_vld),
    .rx_data(rx_data),
    .tx     (tx),
    .txrdy  (txrdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_rxv = 0;
  int cyc = 0;

  // TX model: frame bit vector plus elapsed cycles since acceptance.
  logic        m_busy = 1'b0;
  int          m_elapsed = 0;
  logic [10:0] m_bits = '1;

  // RX scoreboard: bytes that must appear, with the cycle they are due.
  logic [7:0] exp_byte[$];
  int         exp_due[$];
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_busy    = 1'b0;
        m_elapsed = 0;
      end else if (m_busy) begin
        m_elapsed++;
        if (m_elapsed == 11 * DIV) m_busy = 1'b0;
      end else if (tx_vld) begin
        m_busy    = 1'b1;
        m_elapsed = 0;
        m_bits    = {1'b1, ^tx_data, tx_data, 1'b0};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_good = 8'h00;
        exp_byte.delete();
        exp_due.delete();
      end else begin
        check("tx", tx, m_busy ? m_bits[m_elapsed / DIV] : 1'b1);
        check("txrdy", txrdy, !m_busy);
        if (rx_vld) begin
          n_rxv++;
          if (exp_byte.size() == 0) begin
            check("rx_vld_spurious", rx_vld, 1'b0);
          end else begin
            int dt;
            dt = cyc - exp_due[0];
            check("rx_vld_time", (dt >= -2 && dt <= 2), 1'b1);
            check("rx_data", rx_data, exp_byte[0]);
            last_good = exp_byte[0];
            void'(exp_byte.pop_front());
            void'(exp_due.pop_front());
          end
        end else begin
          check("rx_data_hold", rx_data, last_good);
          if (exp_due.size() != 0 && cyc > exp_due[0] + 2) begin
            check("rx_vld_missing", rx_vld, 1'b1);
            void'(exp_byte.pop_front());
            void'(exp_due.pop_front());
          end
        end
      end
    end
  end

  // kind: 0 good, 1 bad parity, 2 bad stop.
  task automatic send_frame(input logic [7:0] d, input int kind, input int gap);
    logic [10:0] bits;
    bits = {(kind != 2), (^d) ^ (kind == 1), d, 1'b0};
    @(posedge clk);
    #1;
    if (kind == 0) begin
      exp_byte.push_back(d);
      exp_due.push_back(cyc + RX_LAT);
    end
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_glitch();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
  endtask

  task automatic tx_request(input logic [7:0] d, input int hold);
    @(posedge clk);
    #1;
    tx_vld  = 1'b1;
    tx_data = d;
    repeat (hold) @(posedge clk);
    #1;
    tx_vld  = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_tx_idle();
    int k;
    k = 0;
    while (!txrdy && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("txrdy_wait", txrdy, 1'b1);
  endtask

  initial begin
    logic [10:0] cap;
    int          low;
    int          v0;

    rst = 1'b0;
    rx = 1'b1;
    tx_vld = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_txrdy", txrdy, 1'b1);
    check("reset_rx_vld", rx_vld, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // TX 0xA5: mid-bit capture of the whole frame, and the busy duration.
    wait_tx_idle();
    tx_request(8'hA5, 1);
    cap = '0;
    low = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (txrdy) break;
      if (k % DIV == DIV / 2) cap[k / DIV] = tx;
      low++;
    end
    check("tx_a5_bits", cap, 11'b10101001010);
    check("tx_a5_busy_cycles", low, 11 * DIV);

    // Reset in the middle of a TX frame.
    wait_tx_idle();
    tx_request(8'h3C, 1);
    repeat (50) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_txrdy", txrdy, 1'b1);
    check("midreset_rx_vld", rx_vld, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("postreset_tx", tx, 1'b1);
    check("postreset_txrdy", txrdy, 1'b1);

    // RX directed: good, bad parity, bad stop, glitch, good.
    v0 = n_rxv;
    send_frame(8'h5A, 0, 4);
    check("rx_5a_data", rx_data, 8'h5A);
    check("rx_5a_pulses", n_rxv - v0, 1);
    v0 = n_rxv;
    send_frame(8'h77, 1, 4);
    send_frame(8'h11, 2, 2 * DIV);
    check("rx_bad_data", rx_data, 8'h5A);
    check("rx_bad_pulses", n_rxv - v0, 0);
    send_glitch();
    check("rx_glitch_pulses", n_rxv - v0, 0);
    send_frame(8'h3C, 0, 4);
    check("rx_3c_data", rx_data, 8'h3C);

    // Full duplex, with an extra request while the transmitter is busy.
    fork
      send_frame(8'hC3, 0, 4);
      begin
        tx_request(8'h81, 1);
        repeat (40) @(posedge clk);
        tx_request(8'hFF, 1);
      end
    join
    wait_tx_idle();
    check("duplex_rx_data", rx_data, 8'hC3);
    low = 0;
    for (int k = 0; k < 11 * DIV; k++) begin
      @(negedge clk);
      if (!txrdy) low++;
    end
    check("busy_req_ignored", low, 0);

    // Randomized concurrent traffic.
    fork
      for (int i = 0; i < 20; i++) begin
        int r;
        r = $urandom_range(0, 8);
        if (r == 8) send_glitch();
        else send_frame(8'($urandom), (r < 6) ? 0 : r - 5, $urandom_range(2, 2 * DIV));
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 200)) @(posedge clk);
        tx_request(8'($urandom), $urandom_range(1, 3));
      end
    join

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (exp_byte.size() == 0 && !m_busy) break;
    end
    #1;
    check("rx_queue_drained", exp_byte.size(), 0);
    check("tx_final_idle", txrdy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
